// File: rtl/ls161_timer_ctrl.sv
// ============================================================================
// ls161_timer_ctrl
// ----------------------------------------------------------------------------
// Sequencer that drives an external 74LS161-style 4-bit counter as a
// programmable period timer. A period is (16 - PRESET) enabled counter cycles.
// The counter is loaded with PRESET, counts up to 15, and then either reloads
// for another period or is left to wrap and the run finishes.
// One-shot mode runs REPEAT+1 periods. Periodic mode runs until ABORT.
//
// Ports
//   CLK         clock, rising edge
//   CLR         synchronous active-high reset
//   START       start request, only honoured in IDLE
//   MODE        0 = one-shot, 1 = periodic (sampled live while running)
//   PRESET[3:0] counter start value, latched at start
//   REPEAT[7:0] extra periods for one-shot mode, latched at start
//   PAUSE       freezes counting and the sequencer while high
//   ABORT       ends an active run through the CLEAR state
//   CNT_Q[3:0]  counter parallel output
//   CNT_RCO     counter ripple-carry (terminal count)
//   CNT_D[3:0]  counter parallel load value
//   CNT_LOAD_n  counter load, active low
//   CNT_ENP     counter count enable P
//   CNT_ENT     counter count enable T
//   CNT_CLR_n   counter clear, active low
//   BUSY        high whenever the sequencer is not idle
//   TICK        one-cycle pulse the cycle after each period end
//   DONE        one-cycle pulse the cycle after the final one-shot period end
//   REMAIN[7:0] periods still to run after the current one
// ============================================================================
module ls161_timer_ctrl (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       START,
   input  logic       MODE,
   input  logic [3:0] PRESET,
   input  logic [7:0] REPEAT,
   input  logic       PAUSE,
   input  logic       ABORT,
   input  logic [3:0] CNT_Q,
   input  logic       CNT_RCO,
   output logic [3:0] CNT_D,
   output logic       CNT_LOAD_n,
   output logic       CNT_ENP,
   output logic       CNT_ENT,
   output logic       CNT_CLR_n,
   output logic       BUSY,
   output logic       TICK,
   output logic       DONE,
   output logic [7:0] REMAIN
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      CLEAR = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] preset_q;
   logic [7:0] remain_q;
   logic       tick_q;
   logic       done_q;

   logic       period_end;
   logic       reload;

   // A real 161 gates RCO with ENT; also requiring Q=15 keeps the terminal
   // decode correct however the board wires the counter's ENT input.
   assign period_end = (state == RUN) && CNT_RCO && (CNT_Q == 4'hF) && !PAUSE;

   // Another period follows this one: periodic mode, or one-shot with
   // periods still outstanding.
   assign reload = period_end && (MODE || (remain_q != 8'd0));

   // Sequencer state, latched run parameters and the registered pulses.
   // ABORT is tested before the period end so an abort on the terminal
   // cycle goes straight to CLEAR with no TICK.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state    <= IDLE;
         preset_q <= 4'd0;
         remain_q <= 8'd0;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  preset_q <= PRESET;
                  remain_q <= REPEAT;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               state <= ABORT ? CLEAR : RUN;
            end
            RUN: begin
               if (ABORT) begin
                  state <= CLEAR;
               end else if (period_end) begin
                  tick_q <= 1'b1;
                  if (reload) begin
                     if (!MODE && (remain_q != 8'd0)) begin
                        remain_q <= remain_q - 8'd1;
                     end
                  end else begin
                     done_q <= 1'b1;
                     state  <= IDLE;
                  end
               end
            end
            CLEAR: begin
               remain_q <= 8'd0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Counter controls. The reload on a period end must be combinational so
   // the counter loads PRESET on the same edge it would otherwise wrap.
   // CLR forces the counter clear immediately, ahead of every other control.
   always_comb begin
      CNT_D      = preset_q;
      CNT_LOAD_n = 1'b1;
      CNT_ENP    = 1'b0;
      CNT_ENT    = 1'b0;
      CNT_CLR_n  = 1'b1;
      if (CLR) begin
         CNT_CLR_n = 1'b0;
      end else begin
         case (state)
            LOAD: begin
               CNT_LOAD_n = 1'b0;
            end
            RUN: begin
               CNT_ENT    = 1'b1;
               CNT_ENP    = !PAUSE;
               CNT_LOAD_n = !(reload && !ABORT);
            end
            CLEAR: begin
               CNT_CLR_n = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign BUSY   = (state != IDLE);
   assign TICK   = tick_q;
   assign DONE   = done_q;
   assign REMAIN = remain_q;

endmodule
